obstacle_field: RTL and testbench
=================================

Name: obstacle_field

Overview:
- Parametrised meteor/obstacle manager: N independently falling obstacles, each with its own spawn timer, pseudo-random X spawn position and per-object fall speed.
- Checks collision against M player bullets and against the ship's bounding box, and reports hits, consumed bullets and obstacles that escaped off the bottom.
- Sits between the player/ammo logic and the colour mapper; advances once per frame_clk (vsync-rate).

Parameters:
- NUM_OBJ, 8, number of obstacle slots (1..16)
- NUM_AMMO, 4, number of bullet channels checked per frame
- OBJ_SIZE, 30, obstacle square edge in pixels
- X_MIN, 5, leftmost legal spawn X
- X_MAX, 636, rightmost screen X; spawn X is at most X_MAX-OBJ_SIZE
- Y_MAX, 476, bottom limit; top edge >= Y_MAX-OBJ_SIZE means escaped
- RESPAWN_FRAMES, 32, idle frames after a hit or escape before the slot re-arms
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
- frame_clk  in  1  frame-rate clock; all state updates on its rising edge
- Reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = advance game; 0 = freeze all state, outputs hold, no pulses
- ammo_x[NUM_AMMO]  in  10  bullet centre X
- ammo_y[NUM_AMMO]  in  10  bullet centre Y
- ammo_valid[NUM_AMMO]  in  1  bullet channel in flight
- ship_x, ship_y  in  10  ship top-left
- ship_size  in  10  ship square edge
- obj_x[NUM_OBJ], obj_y[NUM_OBJ]  out  10  obstacle top-left
- obj_size[NUM_OBJ]  out  10  constant OBJ_SIZE
- obj_active[NUM_OBJ]  out  1  slot visible and falling
- ammo_consumed[NUM_AMMO]  out  1  one-frame pulse: bullet hit an obstacle; ammo logic retires it
- bullet_hit  out  1  one-frame pulse: OR of ammo_consumed
- hit_count  out  5  obstacles destroyed by bullets this frame
- ship_hit  out  1  one-frame pulse: an active obstacle overlapped the ship
- escaped  out  1  one-frame pulse: at least one obstacle left the bottom

Behaviour:
- Per-slot FSM, states IDLE and FALL. Per-slot registers: x, y, speed (2 bits, value 1..3), timer (6 bits).
- Reset (async): LFSR = LFSR_SEED; slot i in IDLE with timer = 4*i (staggered entry), x = 0, y = 0, speed = 1; all pulse outputs 0; obj_active all 0.
- IDLE: timer decrements each enabled frame. At timer==0 the slot is spawn-ready. At most one slot spawns per frame: the lowest-index ready slot. Other ready slots stay at 0 and wait.
- Spawn: x = X_MIN + lfsr[8:0]; if the result exceeds X_MAX-OBJ_SIZE, subtract 256. y = 0. speed = lfsr[10:9], with 0 mapped to 1. State becomes FALL. The LFSR steps every enabled frame, whether or not a spawn occurs.
- FALL, evaluated on pre-update positions, in this priority order:
  1. Bullet hit. Some valid ammo j satisfies obj_x <= ammo_x < obj_x+OBJ_SIZE and obj_y <= ammo_y < obj_y+OBJ_SIZE, with sums computed at 11 bits (no wrap). Result: slot goes to IDLE with timer = RESPAWN_FRAMES-1 and counts once in hit_count.
  2. Ship overlap (AABB, inclusive-exclusive). Result: slot goes to IDLE, ship_hit pulses.
  3. Escape: y + speed >= Y_MAX-OBJ_SIZE. Result: slot goes to IDLE, escaped pulses.
  4. Otherwise y <= y + speed.
- A simultaneous hit and escape counts as a hit only; a simultaneous hit and ship overlap counts as a hit only.
- Bullet arbitration: each bullet consumes at most one obstacle, the lowest-index overlapping active slot. Two bullets inside the same obstacle in one frame: both ammo_consumed bits pulse, the obstacle counts once.
- An IDLE slot never collides; obj_active = (state==FALL).
- enable=0: no register changes (LFSR and timers included); pulse outputs forced 0.
- Reset asserted mid-frame: immediate return to reset values; no partial pulses.
- Latency: collision on frame k gives pulses and deactivation visible after edge k+1.

Decomposition:
- Package obstacle_pkg: obj_state_t enum {IDLE, FALL}; SCREEN_W=640 and SCREEN_H=480 constants; default OBJ_SIZE; the LFSR tap constant.
- Sub-module lfsr16: Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, with enable input and a seed parameter.
- Collision compare is a function inside the package, not a module.

Test Plan:
- Reset, enable=1, no ammo: slot 0 spawns at frame 1, slot 1 at frame 5; the first spawn X equals the value computed from seed ACE1. All spawn X lie in [5, 606].
- Slot 0 at (100,100); ammo 0 at (110,110), valid -> next frame obj_active[0]=0, ammo_consumed=0001, bullet_hit=1, hit_count=1; the slot re-spawns after 32 frames.
- Ammo 0 at (110,110) and ammo 1 at (120,120) inside the same obstacle -> ammo_consumed=0011, hit_count=1.
- Obstacle at y=444 with speed 3, no ammo -> escaped=1 for one frame, obj_active drops; with a bullet hit in the same frame instead -> escaped=0, hit_count=1.
- Ship at (200,400), size 32; obstacle overlapping it -> ship_hit=1 for one frame, slot returns to IDLE.
- Hold enable=0 for 10 frames mid-fall -> obj_y and LFSR unchanged, all pulses 0. Assert Reset while an obstacle is falling -> all obj_active=0 immediately.

Source files
------------

// File: rtl/obstacle_pkg.sv
// Shared types, screen constants and collision helpers for the obstacle field.
package obstacle_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FALL = 1'b1
    } obj_state_t;

    localparam int SCREEN_W         = 640;
    localparam int SCREEN_H         = 480;
    localparam int DEFAULT_OBJ_SIZE = 30;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Sums are widened to 11 bits so a box near the right/bottom edge never wraps.
    function automatic logic point_in_box(input logic [9:0]  px,
                                          input logic [9:0]  py,
                                          input logic [9:0]  bx,
                                          input logic [9:0]  by,
                                          input logic [10:0] size);
        return ({1'b0, px} >= {1'b0, bx}) && ({1'b0, px} < ({1'b0, bx} + size)) &&
               ({1'b0, py} >= {1'b0, by}) && ({1'b0, py} < ({1'b0, by} + size));
    endfunction

    function automatic logic boxes_overlap(input logic [9:0]  ax,
                                           input logic [9:0]  ay,
                                           input logic [10:0] asize,
                                           input logic [9:0]  bx,
                                           input logic [9:0]  by,
                                           input logic [10:0] bsize);
        return ({1'b0, ax} < ({1'b0, bx} + bsize)) && ({1'b0, bx} < ({1'b0, ax} + asize)) &&
               ({1'b0, ay} < ({1'b0, by} + bsize)) && ({1'b0, by} < ({1'b0, ay} + asize));
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that steps only on enabled clocks.
module lfsr16
    import obstacle_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (en_i) begin
            state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/obstacle_field.sv
// Falling-obstacle manager: spawns, moves and retires NUM_OBJ obstacles once per frame,
// colliding them against the player's bullets and ship.
module obstacle_field
    import obstacle_pkg::*;
#(
    parameter int          NUM_OBJ        = 8,
    parameter int          NUM_AMMO       = 4,
    parameter int          OBJ_SIZE       = DEFAULT_OBJ_SIZE,
    parameter int          X_MIN          = 5,
    parameter int          X_MAX          = SCREEN_W - 4,
    parameter int          Y_MAX          = SCREEN_H - 4,
    parameter int          RESPAWN_FRAMES = 32,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                frame_clk,
    input  logic                Reset,
    input  logic                enable,
    input  logic [9:0]          ammo_x        [NUM_AMMO],
    input  logic [9:0]          ammo_y        [NUM_AMMO],
    input  logic [NUM_AMMO-1:0] ammo_valid,
    input  logic [9:0]          ship_x,
    input  logic [9:0]          ship_y,
    input  logic [9:0]          ship_size,
    output logic [9:0]          obj_x         [NUM_OBJ],
    output logic [9:0]          obj_y         [NUM_OBJ],
    output logic [9:0]          obj_size      [NUM_OBJ],
    output logic [NUM_OBJ-1:0]  obj_active,
    output logic [NUM_AMMO-1:0] ammo_consumed,
    output logic                bullet_hit,
    output logic [4:0]          hit_count,
    output logic                ship_hit,
    output logic                escaped
);

    localparam logic [10:0] OBJ_EDGE      = 11'(OBJ_SIZE);
    localparam logic [10:0] SPAWN_X_LIMIT = 11'(X_MAX - OBJ_SIZE);
    localparam logic [10:0] ESCAPE_Y      = 11'(Y_MAX - OBJ_SIZE);
    localparam logic [5:0]  RESPAWN_TIMER = 6'(RESPAWN_FRAMES - 1);

    obj_state_t state_q [NUM_OBJ];
    obj_state_t state_d [NUM_OBJ];
    logic [9:0] x_q     [NUM_OBJ];
    logic [9:0] x_d     [NUM_OBJ];
    logic [9:0] y_q     [NUM_OBJ];
    logic [9:0] y_d     [NUM_OBJ];
    logic [1:0] speed_q [NUM_OBJ];
    logic [1:0] speed_d [NUM_OBJ];
    logic [5:0] timer_q [NUM_OBJ];
    logic [5:0] timer_d [NUM_OBJ];

    logic [15:0]         lfsr;
    logic                lfsr_unused;
    logic [10:0]         spawn_raw;
    logic [9:0]          spawn_x;
    logic [1:0]          spawn_speed;
    logic [NUM_OBJ-1:0]  spawn_sel;
    logic [NUM_OBJ-1:0]  shot;
    logic [NUM_OBJ-1:0]  ship_ovl;
    logic [NUM_OBJ-1:0]  escape_now;
    logic [NUM_AMMO-1:0] consumed_d;
    logic [NUM_AMMO-1:0] consumed_q;
    logic [4:0]          hit_count_d;
    logic [4:0]          hit_count_q;
    logic                ship_hit_d;
    logic                ship_hit_q;
    logic                escaped_d;
    logic                escaped_q;

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk_i  (frame_clk),
        .rst_i  (Reset),
        .en_i   (enable),
        .state_o(lfsr)
    );

    assign lfsr_unused = ^lfsr[15:11];

    // Spawn X folds back by 256 so an obstacle never starts past the right edge.
    always_comb begin
        spawn_raw = 11'(X_MIN) + {2'b00, lfsr[8:0]};
        if (spawn_raw > SPAWN_X_LIMIT) begin
            spawn_raw = spawn_raw - 11'd256;
        end
        spawn_x     = spawn_raw[9:0];
        spawn_speed = (lfsr[10:9] == 2'd0) ? 2'd1 : lfsr[10:9];
    end

    always_comb begin
        logic taken;
        taken     = 1'b0;
        spawn_sel = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (!taken && state_q[i] == IDLE && timer_q[i] == 6'd0) begin
                spawn_sel[i] = 1'b1;
                taken        = 1'b1;
            end
        end
    end

    // Each bullet retires only the lowest-index active obstacle it sits inside.
    always_comb begin
        logic found;
        found      = 1'b0;
        shot       = '0;
        consumed_d = '0;
        for (int j = 0; j < NUM_AMMO; j++) begin
            found = 1'b0;
            if (enable && ammo_valid[j]) begin
                for (int i = 0; i < NUM_OBJ; i++) begin
                    if (!found && state_q[i] == FALL &&
                        point_in_box(ammo_x[j], ammo_y[j], x_q[i], y_q[i], OBJ_EDGE)) begin
                        found         = 1'b1;
                        shot[i]       = 1'b1;
                        consumed_d[j] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            ship_ovl[i]   = (state_q[i] == FALL) &&
                            boxes_overlap(x_q[i], y_q[i], OBJ_EDGE, ship_x, ship_y, {1'b0, ship_size});
            escape_now[i] = (state_q[i] == FALL) && !shot[i] && !ship_ovl[i] &&
                            (({1'b0, y_q[i]} + {9'b0, speed_q[i]}) >= ESCAPE_Y);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            state_d[i] = state_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            speed_d[i] = speed_q[i];
            timer_d[i] = timer_q[i];
            if (enable) begin
                case (state_q[i])
                    IDLE: begin
                        if (timer_q[i] != 6'd0) begin
                            timer_d[i] = timer_q[i] - 6'd1;
                        end else if (spawn_sel[i]) begin
                            state_d[i] = FALL;
                            x_d[i]     = spawn_x;
                            y_d[i]     = 10'd0;
                            speed_d[i] = spawn_speed;
                        end
                    end
                    FALL: begin
                        if (shot[i] || ship_ovl[i] || escape_now[i]) begin
                            state_d[i] = IDLE;
                            timer_d[i] = RESPAWN_TIMER;
                        end else begin
                            y_d[i] = y_q[i] + {8'b0, speed_q[i]};
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        hit_count_d = 5'd0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            hit_count_d = hit_count_d + 5'(shot[i]);
        end
        ship_hit_d = enable && |(ship_ovl & ~shot);
        escaped_d  = enable && |escape_now;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Reset timers are staggered so obstacles enter the screen one after another.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                x_q[i]     <= 10'd0;
                y_q[i]     <= 10'd0;
                speed_q[i] <= 2'd1;
                timer_q[i] <= 6'(4 * i);
            end
            consumed_q  <= '0;
            hit_count_q <= 5'd0;
            ship_hit_q  <= 1'b0;
            escaped_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                speed_q[i] <= speed_d[i];
                timer_q[i] <= timer_d[i];
            end
            consumed_q  <= consumed_d;
            hit_count_q <= hit_count_d;
            ship_hit_q  <= ship_hit_d;
            escaped_q   <= escaped_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            obj_x[i]      = x_q[i];
            obj_y[i]      = y_q[i];
            obj_size[i]   = 10'(OBJ_SIZE);
            obj_active[i] = (state_q[i] == FALL);
        end
    end

    assign ammo_consumed = consumed_q;
    assign bullet_hit    = |consumed_q;
    assign hit_count     = hit_count_q;
    assign ship_hit      = ship_hit_q;
    assign escaped       = escaped_q;

endmodule

// File: tb/tb_obstacle_field.sv
// Scoreboard bench for obstacle_field: a frame-level reference model predicts each frame's
// outputs when inputs are driven, and the scenario tasks compare after the following edge.
module tb_obstacle_field;

    localparam int NO    = 8;
    localparam int NA    = 4;
    localparam int SZ    = 30;
    localparam int ESC_Y = 446;

    logic          frame_clk;
    logic          Reset;
    logic          enable;
    logic [9:0]    ammo_x [NA];
    logic [9:0]    ammo_y [NA];
    logic [NA-1:0] ammo_valid;
    logic [9:0]    ship_x;
    logic [9:0]    ship_y;
    logic [9:0]    ship_size;
    logic [9:0]    obj_x [NO];
    logic [9:0]    obj_y [NO];
    logic [9:0]    obj_size [NO];
    logic [NO-1:0] obj_active;
    logic [NA-1:0] ammo_consumed;
    logic          bullet_hit;
    logic [4:0]    hit_count;
    logic          ship_hit;
    logic          escaped;

    obstacle_field #(
        .NUM_OBJ (NO),
        .NUM_AMMO(NA)
    ) dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .enable       (enable),
        .ammo_x       (ammo_x),
        .ammo_y       (ammo_y),
        .ammo_valid   (ammo_valid),
        .ship_x       (ship_x),
        .ship_y       (ship_y),
        .ship_size    (ship_size),
        .obj_x        (obj_x),
        .obj_y        (obj_y),
        .obj_size     (obj_size),
        .obj_active   (obj_active),
        .ammo_consumed(ammo_consumed),
        .bullet_hit   (bullet_hit),
        .hit_count    (hit_count),
        .ship_hit     (ship_hit),
        .escaped      (escaped)
    );

    typedef struct {
        logic [NO-1:0]    active;
        logic [NO*10-1:0] xs;
        logic [NO*10-1:0] ys;
        logic [NA-1:0]    consumed;
        logic [4:0]       hits;
        logic             ship;
        logic             esc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    logic [15:0] mLfsr;
    bit          mFall  [NO];
    int          mX     [NO];
    int          mY     [NO];
    int          mSpeed [NO];
    int          mTimer [NO];

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    function automatic bit inBox(input int px, input int py, input int bx, input int by, input int s);
        return (px >= bx) && (px < bx + s) && (py >= by) && (py < by + s);
    endfunction

    function automatic bit overlap(input int ax, input int ay, input int as,
                                   input int bx, input int by, input int bs);
        return (ax < bx + bs) && (bx < ax + as) && (ay < by + bs) && (by < ay + as);
    endfunction

    function automatic logic [NO*10-1:0] packVec(input logic [9:0] v [NO]);
        logic [NO*10-1:0] r;
        r = '0;
        for (int i = 0; i < NO; i++) r[i*10 +: 10] = v[i];
        return r;
    endfunction

    function automatic int firstActive();
        for (int i = 0; i < NO; i++) if (mFall[i]) return i;
        return -1;
    endfunction

    task automatic parkShip();
        ship_x = 10'd1000; ship_y = 10'd1000; ship_size = 10'd1;
    endtask

    task automatic clearAmmo();
        ammo_valid = '0;
        for (int j = 0; j < NA; j++) begin ammo_x[j] = 10'd0; ammo_y[j] = 10'd0; end
    endtask

    task automatic modelReset();
        mLfsr = 16'hACE1;
        for (int i = 0; i < NO; i++) begin
            mFall[i] = 0; mX[i] = 0; mY[i] = 0; mSpeed[i] = 1; mTimer[i] = 4 * i;
        end
    endtask

    // One frame of the game rules, applied to the current inputs; result goes to the scoreboard.
    task automatic modelStep();
        exp_t r;
        bit   shotSlot [NO];
        int   chosen;
        int   sx;
        bit   lsb;
        r.consumed = '0; r.hits = 5'd0; r.ship = 1'b0; r.esc = 1'b0;
        for (int i = 0; i < NO; i++) shotSlot[i] = 0;
        if (enable) begin
            for (int j = 0; j < NA; j++) begin
                if (ammo_valid[j]) begin
                    for (int i = 0; i < NO; i++) begin
                        if (mFall[i] && inBox(int'(ammo_x[j]), int'(ammo_y[j]), mX[i], mY[i], SZ)) begin
                            shotSlot[i] = 1; r.consumed[j] = 1'b1;
                            break;
                        end
                    end
                end
            end
            chosen = -1;
            for (int i = 0; i < NO; i++) begin
                if (!mFall[i] && mTimer[i] == 0) begin chosen = i; break; end
            end
            for (int i = 0; i < NO; i++) begin
                if (mFall[i]) begin
                    if (shotSlot[i]) begin
                        mFall[i] = 0; mTimer[i] = 31; r.hits = r.hits + 5'd1;
                    end else if (overlap(mX[i], mY[i], SZ, int'(ship_x), int'(ship_y), int'(ship_size))) begin
                        mFall[i] = 0; mTimer[i] = 31; r.ship = 1'b1;
                    end else if (mY[i] + mSpeed[i] >= ESC_Y) begin
                        mFall[i] = 0; mTimer[i] = 31; r.esc = 1'b1;
                    end else begin
                        mY[i] = mY[i] + mSpeed[i];
                    end
                end else if (mTimer[i] > 0) begin
                    mTimer[i] = mTimer[i] - 1;
                end else if (i == chosen) begin
                    sx = 5 + int'(mLfsr[8:0]);
                    if (sx > 606) sx = sx - 256;
                    mX[i] = sx; mY[i] = 0; mFall[i] = 1;
                    mSpeed[i] = (mLfsr[10:9] == 2'd0) ? 1 : int'(mLfsr[10:9]);
                end
            end
            lsb   = mLfsr[0];
            mLfsr = mLfsr >> 1;
            if (lsb) mLfsr = mLfsr ^ 16'hB400;
        end
        for (int i = 0; i < NO; i++) begin
            r.active[i]       = mFall[i];
            r.xs[i*10 +: 10]  = 10'(mX[i]);
            r.ys[i*10 +: 10]  = 10'(mY[i]);
        end
        sb.push_back(r);
    endtask

    task automatic advance();
        modelStep();
        @(posedge frame_clk);
        #1;
        e = sb.pop_front();
    endtask

    task automatic test_reset();
        Reset = 1'b1; enable = 1'b0; clearAmmo(); parkShip();
        modelReset(); sb.delete();
        #1;
        total++; if (obj_active !== 8'h00) begin bad++; $display("[TB] FAIL reset_active got=%h want=00", obj_active); end
        total++; if ({ammo_consumed, bullet_hit, hit_count, ship_hit, escaped} !== '0) begin bad++;
            $display("[TB] FAIL reset_pulses got=%b/%b/%0d/%b/%b want=0", ammo_consumed, bullet_hit, hit_count, ship_hit, escaped); end
        total++; if (obj_size[3] !== 10'd30) begin bad++; $display("[TB] FAIL reset_size got=%0d want=30", obj_size[3]); end
        total++; if (packVec(obj_x) !== '0 || packVec(obj_y) !== '0) begin bad++; $display("[TB] FAIL reset_pos got=nonzero want=0"); end
        @(posedge frame_clk); #1;
        Reset = 1'b0; enable = 1'b1;
    endtask

    task automatic test_spawn();
        for (int f = 1; f <= 12; f++) begin
            advance();
            total++; if (obj_active !== e.active) begin bad++; $display("[TB] FAIL spawn_active f=%0d got=%h want=%h", f, obj_active, e.active); end
            total++; if (packVec(obj_x) !== e.xs || packVec(obj_y) !== e.ys) begin bad++; $display("[TB] FAIL spawn_pos f=%0d got=%h want=%h", f, packVec(obj_y), e.ys); end
            if (f == 1) begin
                total++; if (obj_x[0] !== 10'd230) begin bad++; $display("[TB] FAIL first_spawn_x got=%0d want=230", obj_x[0]); end
                total++; if (obj_active !== 8'h01) begin bad++; $display("[TB] FAIL first_spawn got=%h want=01", obj_active); end
            end
            if (f == 4) begin
                total++; if (obj_active !== 8'h01) begin bad++; $display("[TB] FAIL slot1_early got=%h want=01", obj_active); end
            end
            if (f == 5) begin
                total++; if (obj_active !== 8'h03) begin bad++; $display("[TB] FAIL slot1_spawn got=%h want=03", obj_active); end
            end
            for (int i = 0; i < NO; i++) begin
                if (obj_active[i]) begin
                    total++; if (obj_x[i] < 10'd5 || obj_x[i] > 10'd606) begin bad++; $display("[TB] FAIL spawn_range slot=%0d got=%0d want=5..606", i, obj_x[i]); end
                end
            end
        end
    endtask

    task automatic test_bullet_hit();
        total++; if (!mFall[0]) begin bad++; $display("[TB] FAIL hit_setup got=idle want=falling"); end
        ammo_x[0] = 10'(mX[0] + 10); ammo_y[0] = 10'(mY[0] + 10); ammo_valid = 4'b0001;
        advance();
        clearAmmo();
        total++; if (ammo_consumed !== 4'b0001 || ammo_consumed !== e.consumed) begin bad++; $display("[TB] FAIL hit_consumed got=%b want=0001", ammo_consumed); end
        total++; if (bullet_hit !== 1'b1) begin bad++; $display("[TB] FAIL hit_bullet got=%b want=1", bullet_hit); end
        total++; if (hit_count !== 5'd1) begin bad++; $display("[TB] FAIL hit_count got=%0d want=1", hit_count); end
        total++; if (obj_active[0] !== 1'b0) begin bad++; $display("[TB] FAIL hit_deactivate got=%b want=0", obj_active[0]); end
        advance();
        total++; if (bullet_hit !== 1'b0 || ammo_consumed !== 4'b0000) begin bad++; $display("[TB] FAIL hit_pulse_width got=%b want=0", bullet_hit); end
        for (int k = 2; k <= 32; k++) begin
            advance();
            total++; if (obj_active !== e.active || escaped !== e.esc) begin bad++; $display("[TB] FAIL respawn_track k=%0d got=%h want=%h", k, obj_active, e.active); end
            if (k == 31) begin
                total++; if (obj_active[0] !== 1'b0) begin bad++; $display("[TB] FAIL respawn_early got=%b want=0", obj_active[0]); end
            end
            if (k == 32) begin
                total++; if (obj_active[0] !== 1'b1) begin bad++; $display("[TB] FAIL respawn got=%b want=1", obj_active[0]); end
            end
        end
    endtask

    task automatic test_double_hit();
        total++; if (!mFall[0]) begin bad++; $display("[TB] FAIL double_setup got=idle want=falling"); end
        ammo_x[0] = 10'(mX[0] + 10); ammo_y[0] = 10'(mY[0] + 10);
        ammo_x[1] = 10'(mX[0] + 20); ammo_y[1] = 10'(mY[0] + 20);
        ammo_valid = 4'b0011;
        advance();
        clearAmmo();
        total++; if (ammo_consumed !== 4'b0011) begin bad++; $display("[TB] FAIL double_consumed got=%b want=0011", ammo_consumed); end
        total++; if (hit_count !== 5'd1 || hit_count !== e.hits) begin bad++; $display("[TB] FAIL double_count got=%0d want=1", hit_count); end
        total++; if (obj_active !== e.active) begin bad++; $display("[TB] FAIL double_active got=%h want=%h", obj_active, e.active); end
    endtask

    task automatic test_ship_hit();
        int s;
        s = firstActive();
        total++; if (s < 0) begin bad++; $display("[TB] FAIL ship_setup got=none want=active"); end
        else begin
            ship_x = 10'(mX[s] + 5); ship_y = 10'(mY[s] + 5); ship_size = 10'd32;
            advance();
            parkShip();
            total++; if (ship_hit !== 1'b1 || ship_hit !== e.ship) begin bad++; $display("[TB] FAIL ship_hit got=%b want=1", ship_hit); end
            total++; if (obj_active[s] !== 1'b0) begin bad++; $display("[TB] FAIL ship_deactivate slot=%0d got=%b want=0", s, obj_active[s]); end
            total++; if (hit_count !== 5'd0) begin bad++; $display("[TB] FAIL ship_no_bullet got=%0d want=0", hit_count); end
            advance();
            total++; if (ship_hit !== 1'b0) begin bad++; $display("[TB] FAIL ship_pulse_width got=%b want=0", ship_hit); end
        end
    endtask

    task automatic test_escape();
        int slot;
        int guard;
        for (int phase = 0; phase < 2; phase++) begin
            slot = -1; guard = 0;
            while (slot < 0 && guard < 1500) begin
                for (int i = 0; i < NO; i++) if (slot < 0 && mFall[i] && mY[i] + mSpeed[i] >= ESC_Y) slot = i;
                if (slot < 0) begin
                    advance(); guard++;
                    total++; if (obj_active !== e.active || escaped !== e.esc) begin bad++; $display("[TB] FAIL fall_track got=%h want=%h", obj_active, e.active); end
                end
            end
            total++;
            if (slot < 0) begin
                bad++; $display("[TB] FAIL escape_wait got=timeout want=escape");
            end else begin
                if (phase == 1) begin
                    ammo_x[0] = 10'(mX[slot] + 10); ammo_y[0] = 10'(mY[slot] + 10); ammo_valid = 4'b0001;
                end
                advance();
                clearAmmo();
                if (phase == 0) begin
                    if (escaped !== 1'b1) begin bad++; $display("[TB] FAIL escape_pulse got=%b want=1", escaped); end
                end else begin
                    if (escaped !== e.esc || hit_count !== e.hits || e.hits == 5'd0) begin bad++;
                        $display("[TB] FAIL hit_beats_escape got=%b/%0d want=%b/%0d", escaped, hit_count, e.esc, e.hits); end
                end
                total++; if (obj_active[slot] !== 1'b0) begin bad++; $display("[TB] FAIL escape_deactivate slot=%0d got=%b want=0", slot, obj_active[slot]); end
                advance();
                total++; if (escaped !== e.esc) begin bad++; $display("[TB] FAIL escape_after got=%b want=%b", escaped, e.esc); end
            end
        end
    endtask

    task automatic test_enable();
        int s;
        int guard;
        guard = 0;
        while (firstActive() < 0 && guard < 100) begin advance(); guard++; end
        s = firstActive();
        total++; if (s < 0) begin bad++; $display("[TB] FAIL freeze_setup got=none want=active"); end
        else begin
            ammo_x[0] = 10'(mX[s] + 10); ammo_y[0] = 10'(mY[s] + 10); ammo_valid = 4'b0001;
            enable = 1'b0;
            for (int f = 0; f < 10; f++) begin
                advance();
                total++; if (packVec(obj_y) !== e.ys || obj_active !== e.active) begin bad++; $display("[TB] FAIL freeze_state f=%0d got=%h want=%h", f, packVec(obj_y), e.ys); end
                total++; if ({ammo_consumed, bullet_hit, hit_count, ship_hit, escaped} !== '0) begin bad++; $display("[TB] FAIL freeze_pulses f=%0d got=%b want=0", f, ammo_consumed); end
            end
            clearAmmo();
            enable = 1'b1;
            for (int f = 0; f < 8; f++) begin
                advance();
                total++; if (packVec(obj_x) !== e.xs || packVec(obj_y) !== e.ys) begin bad++; $display("[TB] FAIL resume_pos f=%0d got=%h want=%h", f, packVec(obj_x), e.xs); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while (firstActive() < 0 && guard < 100) begin advance(); guard++; end
        total++; if (obj_active === 8'h00) begin bad++; $display("[TB] FAIL midreset_setup got=00 want=nonzero"); end
        #2;
        Reset = 1'b1;
        #1;
        total++; if (obj_active !== 8'h00) begin bad++; $display("[TB] FAIL midreset_active got=%h want=00", obj_active); end
        total++; if ({ammo_consumed, hit_count, ship_hit, escaped} !== '0) begin bad++; $display("[TB] FAIL midreset_pulses got=nonzero want=0"); end
        modelReset(); sb.delete();
        @(posedge frame_clk); #1;
        Reset = 1'b0;
        advance();
        total++; if (obj_x[0] !== 10'd230 || obj_active !== 8'h01) begin bad++; $display("[TB] FAIL post_reset_spawn got=%0d/%h want=230/01", obj_x[0], obj_active); end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_bullet_hit();
        test_double_hit();
        test_ship_hit();
        test_escape();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
